// File: rtl/avalon_io_bridge.sv
// Pin-level bridge: deserialises strobed nibbles into core words and serialises core words back out under pin acks.
// Optional macro AVALON_IO_BRIDGE_LOOPBACK_EN adds a loopback input that routes completed RX words straight into TX.
module avalon_io_bridge #(
  parameter int DATA_W = 8,
  parameter int NIB_W  = 4,
  parameter int EF_N   = 2
) (
  input  logic              CLK,
  input  logic              RST,
`ifdef AVALON_IO_BRIDGE_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic [NIB_W-1:0]  pin_data_in,
  input  logic              pin_strobe,
  input  logic              pin_ack,
  input  logic [EF_N-1:0]   pin_ef,
  output logic [NIB_W-1:0]  pin_data_out,
  output logic              pin_out_valid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_rvalid,
  input  logic              core_rready,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              core_wvalid,
  output logic              core_wready,
  output logic [EF_N-1:0]   core_ef,
  output logic              overrun
);

  localparam int SLOTS = DATA_W / NIB_W;
  localparam int CNT_W = (SLOTS > 2) ? $clog2(SLOTS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SLOTS - 1);

  typedef enum logic { COLLECT, FULL } rx_state_t;
  typedef enum logic { IDLE, SHIFT } tx_state_t;

  rx_state_t rx_state;
  tx_state_t tx_state;

  logic strobe_s1, strobe_s2, strobe_d3;
  logic ack_s1, ack_s2, ack_d3;
  logic [NIB_W-1:0] data_s1, data_s2;
  logic [EF_N-1:0] ef_s1, ef_s2;

  logic strobe_edge, ack_edge;
  logic lb_mode, lb_push;
  logic tx_load_en;
  logic [DATA_W-1:0] tx_load_word;

  logic [CNT_W-1:0] rx_cnt, tx_cnt;
  logic [DATA_W-1:0] rdata_q, shreg;
  logic rvalid_q, overrun_q;

  // Data rides a two-flop chain parallel to the strobe so the nibble lines up with the detected edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      strobe_s1 <= 1'b0;
      strobe_s2 <= 1'b0;
      strobe_d3 <= 1'b0;
      ack_s1    <= 1'b0;
      ack_s2    <= 1'b0;
      ack_d3    <= 1'b0;
      data_s1   <= '0;
      data_s2   <= '0;
      ef_s1     <= '0;
      ef_s2     <= '0;
    end else begin
      strobe_s1 <= pin_strobe;
      strobe_s2 <= strobe_s1;
      strobe_d3 <= strobe_s2;
      ack_s1    <= pin_ack;
      ack_s2    <= ack_s1;
      ack_d3    <= ack_s2;
      data_s1   <= pin_data_in;
      data_s2   <= data_s1;
      ef_s1     <= pin_ef;
      ef_s2     <= ef_s1;
    end
  end

  assign strobe_edge = strobe_s2 & ~strobe_d3;
  assign ack_edge    = ack_s2 & ~ack_d3;

`ifdef AVALON_IO_BRIDGE_LOOPBACK_EN
  assign lb_mode      = loopback;
  assign lb_push      = loopback && (rx_state == FULL) && (tx_state == IDLE);
  assign tx_load_word = lb_push ? rdata_q : core_wdata;
`else
  assign lb_mode      = 1'b0;
  assign lb_push      = 1'b0;
  assign tx_load_word = core_wdata;
`endif
  assign tx_load_en = lb_push || (core_wvalid && !lb_mode);

  // RX assembles LS nibble first; a word waiting in FULL drops further nibbles and flags overrun.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_state  <= COLLECT;
      rx_cnt    <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (rx_state)
        COLLECT: begin
          if (strobe_edge) begin
            for (int i = 0; i < SLOTS; i++) begin
              if (rx_cnt == CNT_W'(i)) rdata_q[i*NIB_W +: NIB_W] <= data_s2;
            end
            if (rx_cnt == LAST) begin
              rx_cnt   <= '0;
              rx_state <= FULL;
              rvalid_q <= !lb_mode;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
        end
        FULL: begin
          if (strobe_edge) overrun_q <= 1'b1;
          if (lb_push || (rvalid_q && core_rready)) begin
            rx_state <= COLLECT;
            rvalid_q <= 1'b0;
          end else begin
            rvalid_q <= !lb_mode;
          end
        end
        default: rx_state <= COLLECT;
      endcase
    end
  end

  // TX presents nibble 0 on load and advances one nibble per detected ack edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_state      <= IDLE;
      tx_cnt        <= '0;
      shreg         <= '0;
      pin_data_out  <= '0;
      pin_out_valid <= 1'b0;
      core_wready   <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: begin
          if (tx_load_en) begin
            tx_state      <= SHIFT;
            tx_cnt        <= '0;
            shreg         <= tx_load_word >> NIB_W;
            pin_data_out  <= tx_load_word[NIB_W-1:0];
            pin_out_valid <= 1'b1;
            core_wready   <= 1'b0;
          end
        end
        SHIFT: begin
          if (ack_edge) begin
            if (tx_cnt == LAST) begin
              tx_state      <= IDLE;
              tx_cnt        <= '0;
              pin_data_out  <= '0;
              pin_out_valid <= 1'b0;
              core_wready   <= 1'b1;
            end else begin
              tx_cnt       <= tx_cnt + 1'b1;
              pin_data_out <= shreg[NIB_W-1:0];
              shreg        <= shreg >> NIB_W;
            end
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  assign core_rdata  = rdata_q;
  assign core_rvalid = rvalid_q;
  assign overrun     = overrun_q;
  assign core_ef     = ef_s2;

endmodule

// File: tb/tb_avalon_io_bridge.sv
// Self-checking bench for avalon_io_bridge: queue-based transaction model compared every cycle plus directed literal checks.
// Exercises the loopback path only when AVALON_IO_BRIDGE_LOOPBACK_EN is defined.
module tb_avalon_io_bridge;

  localparam int DATA_W = 8;
  localparam int NIB_W  = 4;
  localparam int EF_N   = 2;
  localparam int SLOTS  = DATA_W / NIB_W;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              loopback = 1'b0;
  logic [NIB_W-1:0]  pin_data_in = '0;
  logic              pin_strobe = 1'b0;
  logic              pin_ack = 1'b0;
  logic [EF_N-1:0]   pin_ef = '0;
  logic [NIB_W-1:0]  pin_data_out;
  logic              pin_out_valid;
  logic [DATA_W-1:0] core_rdata;
  logic              core_rvalid;
  logic              core_rready = 1'b0;
  logic [DATA_W-1:0] core_wdata = '0;
  logic              core_wvalid = 1'b0;
  logic              core_wready;
  logic [EF_N-1:0]   core_ef;
  logic              overrun;

  int testsRun = 0;
  int testsFailed = 0;

  avalon_io_bridge #(.DATA_W(DATA_W), .NIB_W(NIB_W), .EF_N(EF_N)) dut (
    .CLK(CLK),
    .RST(RST),
`ifdef AVALON_IO_BRIDGE_LOOPBACK_EN
    .loopback(loopback),
`endif
    .pin_data_in(pin_data_in),
    .pin_strobe(pin_strobe),
    .pin_ack(pin_ack),
    .pin_ef(pin_ef),
    .pin_data_out(pin_data_out),
    .pin_out_valid(pin_out_valid),
    .core_rdata(core_rdata),
    .core_rvalid(core_rvalid),
    .core_rready(core_rready),
    .core_wdata(core_wdata),
    .core_wvalid(core_wvalid),
    .core_wready(core_wready),
    .core_ef(core_ef),
    .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Transaction model: pin history as sampled at each edge, RX nibble queue, TX nibble queue.
  logic [3:0] hStrobe = '0;
  logic [3:0] hAck = '0;
  logic [NIB_W-1:0] hData [0:3];
  logic [EF_N-1:0] hEf [0:1];
  logic [NIB_W-1:0] rxQ[$];
  logic [NIB_W-1:0] txQ[$];
  logic [DATA_W-1:0] mWord = '0;
  logic mFull = 1'b0;
  logic mRvalid = 1'b0;
  logic mOverrun = 1'b0;

  initial begin
    for (int i = 0; i < 4; i++) hData[i] = '0;
    hEf[0] = '0;
    hEf[1] = '0;
  end

  always @(posedge CLK) begin
    logic rxEv, txEv, txWasEmpty, pushed, lb;
    lb = 1'b0;
`ifdef AVALON_IO_BRIDGE_LOOPBACK_EN
    lb = loopback;
`endif
    hStrobe = {hStrobe[2:0], RST ? 1'b0 : pin_strobe};
    hAck    = {hAck[2:0], RST ? 1'b0 : pin_ack};
    for (int i = 3; i > 0; i--) hData[i] = hData[i-1];
    hData[0] = RST ? '0 : pin_data_in;
    hEf[1] = hEf[0];
    hEf[0] = RST ? '0 : pin_ef;
    if (RST) begin
      rxQ.delete();
      txQ.delete();
      mWord = '0;
      mFull = 1'b0;
      mRvalid = 1'b0;
      mOverrun = 1'b0;
    end else begin
      rxEv = hStrobe[2] && !hStrobe[3];
      txEv = hAck[2] && !hAck[3];
      txWasEmpty = (txQ.size() == 0);
      pushed = 1'b0;
      if (!txWasEmpty && txEv) void'(txQ.pop_front());
      if (mFull) begin
        if (rxEv) mOverrun = 1'b1;
        if (lb && txWasEmpty) begin
          for (int i = 0; i < SLOTS; i++) txQ.push_back(mWord[i*NIB_W +: NIB_W]);
          mFull = 1'b0;
          pushed = 1'b1;
        end else if (mRvalid && core_rready) begin
          mFull = 1'b0;
        end
      end else if (rxEv) begin
        rxQ.push_back(hData[2]);
        if (rxQ.size() == SLOTS) begin
          mWord = '0;
          for (int i = 0; i < SLOTS; i++) mWord = mWord | (DATA_W'(rxQ[i]) << (i * NIB_W));
          rxQ.delete();
          mFull = 1'b1;
        end
      end
      if (txWasEmpty && !pushed && core_wvalid && !lb) begin
        for (int i = 0; i < SLOTS; i++) txQ.push_back(core_wdata[i*NIB_W +: NIB_W]);
      end
      mRvalid = mFull && !lb;
    end
  end

  // Compare process: checked every cycle on the falling edge.
  always @(negedge CLK) begin
    checkOutput("rvalid", core_rvalid, mRvalid);
    if (mRvalid) checkOutput("rdata", core_rdata, mWord);
    checkOutput("overrun", overrun, mOverrun);
    checkOutput("out_valid", pin_out_valid, txQ.size() != 0);
    checkOutput("data_out", pin_data_out, (txQ.size() != 0) ? txQ[0] : '0);
    checkOutput("wready", core_wready, txQ.size() == 0);
    checkOutput("core_ef", core_ef, hEf[1]);
  end

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge CLK);
  endtask

  task automatic sendNibble(input logic [NIB_W-1:0] nib);
    pin_data_in = nib;
    pin_strobe = 1'b1;
    applyStimulus(4);
    pin_strobe = 1'b0;
    applyStimulus(4);
  endtask

  task automatic pulseAck();
    pin_ack = 1'b1;
    applyStimulus(4);
    pin_ack = 1'b0;
    applyStimulus(4);
  endtask

  task automatic pulseWrite(input logic [DATA_W-1:0] w);
    core_wdata = w;
    core_wvalid = 1'b1;
    applyStimulus(1);
    core_wvalid = 1'b0;
  endtask

  task automatic handshake();
    core_rready = 1'b1;
    applyStimulus(1);
    core_rready = 1'b0;
  endtask

  initial begin
    // Reset with inputs toggling.
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      pin_strobe  = 1'($urandom_range(0, 1));
      pin_ack     = 1'($urandom_range(0, 1));
      pin_ef      = EF_N'($urandom);
      pin_data_in = NIB_W'($urandom);
      core_wvalid = 1'($urandom_range(0, 1));
      core_rready = 1'($urandom_range(0, 1));
      core_wdata  = DATA_W'($urandom);
    end
    applyStimulus(1);
    checkOutput("rst_rvalid", core_rvalid, 0);
    checkOutput("rst_out_valid", pin_out_valid, 0);
    checkOutput("rst_wready", core_wready, 1);
    checkOutput("rst_core_ef", core_ef, 0);
    checkOutput("rst_overrun", overrun, 0);
    RST = 1'b0;
    pin_strobe = 1'b0;
    pin_ack = 1'b0;
    pin_ef = '0;
    pin_data_in = '0;
    core_wvalid = 1'b0;
    core_rready = 1'b0;
    core_wdata = '0;
    applyStimulus(4);

    // RX word 0xA5 with exact latency.
    sendNibble(4'h5);
    pin_data_in = 4'hA;
    pin_strobe = 1'b1;
    applyStimulus(2);
    checkOutput("rx_latency_early", core_rvalid, 0);
    applyStimulus(1);
    checkOutput("rx_latency_rise", core_rvalid, 1);
    checkOutput("rx_word", core_rdata, 8'hA5);
    applyStimulus(1);
    pin_strobe = 1'b0;
    applyStimulus(4);
    checkOutput("rx_hold_valid", core_rvalid, 1);
    checkOutput("rx_hold_data", core_rdata, 8'hA5);

    // Overrun while FULL, then handshake and a clean follow-up word.
    sendNibble(4'h3);
    checkOutput("ovr_set", overrun, 1);
    checkOutput("ovr_data_kept", core_rdata, 8'hA5);
    handshake();
    checkOutput("rx_released", core_rvalid, 0);
    sendNibble(4'h7);
    sendNibble(4'h2);
    checkOutput("rx_word2", core_rdata, 8'h27);
    checkOutput("ovr_sticky", overrun, 1);
    handshake();

    // TX word 0x3C.
    pulseWrite(8'h3C);
    checkOutput("tx_nib0", pin_data_out, 4'hC);
    checkOutput("tx_valid0", pin_out_valid, 1);
    checkOutput("tx_busy", core_wready, 0);
    pulseAck();
    checkOutput("tx_nib1", pin_data_out, 4'h3);
    pulseAck();
    checkOutput("tx_done_valid", pin_out_valid, 0);
    checkOutput("tx_done_wready", core_wready, 1);
    pulseAck();
    checkOutput("tx_idle_ack", pin_out_valid, 0);
    checkOutput("tx_idle_data", pin_data_out, 0);

    // Reset in the middle of RX and TX.
    sendNibble(4'hE);
    pulseWrite(8'h81);
    RST = 1'b1;
    applyStimulus(1);
    RST = 1'b0;
    checkOutput("mid_rst_wready", core_wready, 1);
    checkOutput("mid_rst_out_valid", pin_out_valid, 0);
    checkOutput("mid_rst_overrun", overrun, 0);
    sendNibble(4'h4);
    checkOutput("mid_rst_no_rvalid", core_rvalid, 0);
    sendNibble(4'hB);
    checkOutput("mid_rst_word", core_rdata, 8'hB4);
    handshake();

    // External flags delayed by two cycles.
    pin_ef = 2'b01;
    applyStimulus(1);
    checkOutput("ef_d1", core_ef, 2'b00);
    applyStimulus(1);
    checkOutput("ef_d2", core_ef, 2'b01);
    pin_ef = 2'b10;
    applyStimulus(1);
    checkOutput("ef_d1b", core_ef, 2'b01);
    applyStimulus(1);
    checkOutput("ef_d2b", core_ef, 2'b10);

`ifdef AVALON_IO_BRIDGE_LOOPBACK_EN
    // Loopback: RX word goes straight to TX without core_rvalid.
    loopback = 1'b1;
    sendNibble(4'h1);
    sendNibble(4'h2);
    checkOutput("lb_rvalid", core_rvalid, 0);
    checkOutput("lb_nib0", pin_data_out, 4'h1);
    checkOutput("lb_valid", pin_out_valid, 1);
    pulseAck();
    checkOutput("lb_nib1", pin_data_out, 4'h2);
    pulseAck();
    checkOutput("lb_done", pin_out_valid, 0);
    loopback = 1'b0;
    applyStimulus(2);
`endif

    applyStimulus(2);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
